pwm_duty_sequencer: RTL and testbench
=====================================

Name: pwm_duty_sequencer

Overview:
- Controller that drives the duty-cycle step inputs of the PWM generator. It converts an absolute target duty, or single manual step requests, into rate-limited one-cycle increase/decrease pulses.
- Keeps a shadow copy of the generator's duty value and reports completion.
- Sits between the host/button logic and the PWM generator's step inputs. Pulse spacing is long enough for the generator's slow-enable step detector to register each pulse.

Parameters:
- DUTY_W, 4, width of duty values.
- DUTY_MAX, 10, highest legal duty step (100%).
- DUTY_INIT, 5, shadow duty after reset; must equal the generator's reset duty.
- GAP_W, 8, width of the inter-pulse gap counter.
- STEP_GAP, 4, cycles from one step pulse to the next; legal range 2..2^GAP_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  global enable; low freezes sequencing.
- tgt_valid  in  1  host presents target duty.
- tgt_ready  out  1  sequencer can accept a target.
- tgt_duty  in  DUTY_W  requested absolute duty.
- man_inc  in  1  single-step increase request (already debounced, one-cycle).
- man_dec  in  1  single-step decrease request.
- inc_pulse  out  1  one-cycle step-up pulse to the PWM generator.
- dec_pulse  out  1  one-cycle step-down pulse to the PWM generator.
- duty_shadow  out  DUTY_W  sequencer's copy of the current duty.
- busy  out  1  ramp or gap in progress.
- done  out  1  one-cycle pulse when a target ramp completes.
- err_range  out  1  one-cycle pulse when a target was clamped.
- man_drop  out  1  one-cycle pulse when a manual request was discarded.

Behaviour:
- Reset (async, rst=1): state IDLE, duty_shadow=DUTY_INIT, gap counter 0, target reg=DUTY_INIT.
  - All pulse outputs and busy are 0. tgt_ready is 0 while rst is asserted.
- States: IDLE, STEP, GAP, DONE. All outputs are registered.
- IDLE:
  - tgt_ready = ena.
  - On tgt_valid & tgt_ready, latch the target. If tgt_duty > DUTY_MAX, clamp it to DUTY_MAX and pulse err_range in the next cycle.
  - If the latched target equals duty_shadow, go to DONE with no step pulse. Otherwise go to STEP.
- STEP:
  - One cycle long.
  - Asserts inc_pulse if target > shadow, else dec_pulse.
  - Updates duty_shadow by ±1 on the same edge that raises the pulse.
  - Loads the gap counter with STEP_GAP-1, then goes to GAP.
- GAP:
  - Counter decrements each enabled cycle.
  - At 0: if this was a target ramp and shadow ≠ target, go to STEP; if shadow = target, go to DONE; if this was a manual step, go to IDLE with no done.
- DONE: done=1 for one cycle, then IDLE.
- Pulse spacing: consecutive step pulses are exactly STEP_GAP cycles apart, measured rising edge to rising edge, while ena=1.
- busy=1 in STEP, GAP and DONE. tgt_ready=0 whenever busy.
- Manual steps (IDLE only, no tgt_valid accepted that cycle):
  - man_inc with shadow < DUTY_MAX gives one inc_pulse next cycle, then GAP.
  - man_dec with shadow > 0 gives one dec_pulse, then GAP.
  - A request at the limit is ignored silently, with no pulse and no man_drop.
- Simultaneous events:
  - tgt_valid accepted together with man_inc/man_dec: the target wins, manual is dropped, man_drop pulses.
  - man_inc and man_dec in the same cycle: both dropped, man_drop pulses.
  - Manual request while busy: dropped, man_drop pulses.
- ena=0:
  - State, counter and shadow hold.
  - inc_pulse and dec_pulse are forced 0, and no STEP is entered.
  - A STEP in progress when ena falls completes its single pulse. The freeze takes effect on the next state.
  - Resumes exactly where it stopped.
- Arithmetic: shadow never leaves 0..DUTY_MAX. Comparisons are unsigned at DUTY_W bits.
- Reset mid-ramp: immediate return to reset values. Any pulse in flight is cut.
  - The PWM generator must be reset together with this block so its duty agrees with duty_shadow.

Decomposition:
- Shared package:
  - state enum (IDLE/STEP/GAP/DONE);
  - DUTY_W/DUTY_MAX/DUTY_INIT defaults;
  - a step-direction type (UP/DOWN).
- One natural sub-module: pwm_gap_timer (loadable down-counter with enable and zero flag) for the inter-pulse spacing.

Test Plan:
- Reset, then target 8 -> three inc_pulses at cycles t+1, t+5, t+9; shadow 6,7,8; done pulses once after the last gap; tgt_ready returns 1.
- From shadow 8, target 2 -> six dec_pulses spaced 4 cycles apart; shadow ends at 2; err_range stays 0.
- Target 13 -> err_range pulse; ramp stops at 10; a subsequent man_inc produces no pulse and no man_drop.
- Target equal to the current shadow (5 after reset) -> no step pulses; done exactly 2 cycles after acceptance.
- man_inc during a ramp, and man_inc+man_dec together in IDLE -> man_drop pulses each time; shadow unaffected by the drops.
- ena dropped for 10 cycles mid-GAP, then rst asserted mid-ramp -> no pulses while ena=0; spacing resumes with the remaining count; on rst, shadow returns to 5 and busy drops asynchronously.

Source files
------------

// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared types and default sizing for the PWM duty sequencer.
package pwm_duty_sequencer_pkg;

  localparam int DUTY_W_DEF    = 4;
  localparam int DUTY_MAX_DEF  = 10;
  localparam int DUTY_INIT_DEF = 5;

  typedef enum logic [1:0] {IDLE, STEP, GAP, DONE} seq_state_e;

  typedef enum logic {UP, DOWN} step_dir_e;

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Host/button side and generator side signals of the duty sequencer.
interface pwm_duty_sequencer_if #(parameter int DUTY_W = 4);

  logic              ena;
  logic              tgt_valid;
  logic              tgt_ready;
  logic [DUTY_W-1:0] tgt_duty;
  logic              man_inc;
  logic              man_dec;
  logic              inc_pulse;
  logic              dec_pulse;
  logic [DUTY_W-1:0] duty_shadow;
  logic              busy;
  logic              done;
  logic              err_range;
  logic              man_drop;

  modport master (
    output ena, tgt_valid, tgt_duty, man_inc, man_dec,
    input  tgt_ready, inc_pulse, dec_pulse, duty_shadow, busy, done, err_range, man_drop
  );

  modport slave (
    input  ena, tgt_valid, tgt_duty, man_inc, man_dec,
    output tgt_ready, inc_pulse, dec_pulse, duty_shadow, busy, done, err_range, man_drop
  );

endinterface

// File: rtl/pwm_gap_timer.sv
// Loadable down-counter that spaces consecutive step pulses.
module pwm_gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [GAP_W-1:0] load_val,
  output logic             zero,
  output logic             zero_nxt
);

  logic [GAP_W-1:0] cnt;

  // Load wins over counting; the count parks at zero and holds while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (en && !zero)    cnt <= cnt - 1'b1;
  end

  assign zero     = (cnt == '0);
  // Counter reaches zero on this edge; lets the owner leave GAP without an extra idle cycle.
  assign zero_nxt = en && (cnt == GAP_W'(1));

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Turns absolute duty targets or manual steps into rate-limited inc/dec pulses
// for the PWM generator, tracking a shadow copy of the generator's duty.
module pwm_duty_sequencer
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int DUTY_MAX  = DUTY_MAX_DEF,
  parameter int DUTY_INIT = DUTY_INIT_DEF,
  parameter int GAP_W     = 8,
  parameter int STEP_GAP  = 4
) (
  input logic                 clk,
  input logic                 rst,
  pwm_duty_sequencer_if.slave bus
);

  localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);
  localparam logic [GAP_W-1:0]  GAP_LD = GAP_W'(STEP_GAP - 1);

  seq_state_e        state_q, state_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d, clamp;
  logic              man_q, man_d;
  logic              err_d, drop_d, ready_q;
  logic              accept, any_man, gap_zero, gap_zero_nxt, gap_hit;
  step_dir_e         dir;

  assign clamp   = (bus.tgt_duty > MAX_V) ? MAX_V : bus.tgt_duty;
  // Registered idle flag gated by ena, so a host never sees ready while frozen.
  assign bus.tgt_ready = ready_q & bus.ena;
  assign accept  = bus.tgt_valid & bus.tgt_ready;
  assign any_man = bus.man_inc | bus.man_dec;
  assign dir     = (tgt_q > shadow_gt_guard()) ? UP : DOWN;
  assign gap_hit = (state_q == GAP) && bus.ena && (gap_zero || gap_zero_nxt);

  function automatic logic [DUTY_W-1:0] shadow_gt_guard();
    return bus.duty_shadow;
  endfunction

  pwm_gap_timer #(.GAP_W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == STEP),
    .en       (bus.ena && (state_q == GAP)),
    .load_val (GAP_LD),
    .zero     (gap_zero),
    .zero_nxt (gap_zero_nxt)
  );

  // Next-state, target latch and drop/range flags.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    man_d   = man_q;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = clamp;
          man_d   = 1'b0;
          err_d   = (bus.tgt_duty > MAX_V);
          drop_d  = any_man;
          state_d = (clamp == bus.duty_shadow) ? DONE : STEP;
        end else if ((bus.man_inc && bus.man_dec) || (!bus.ena && any_man)) begin
          drop_d = 1'b1;
        end else if (bus.man_inc && (bus.duty_shadow < MAX_V)) begin
          tgt_d   = bus.duty_shadow + 1'b1;
          man_d   = 1'b1;
          state_d = STEP;
        end else if (bus.man_dec && (bus.duty_shadow != '0)) begin
          tgt_d   = bus.duty_shadow - 1'b1;
          man_d   = 1'b1;
          state_d = STEP;
        end
      end
      STEP: begin
        drop_d  = any_man;
        state_d = GAP;
      end
      GAP: begin
        drop_d = any_man;
        if (gap_hit) begin
          if (man_q)                         state_d = IDLE;
          else if (bus.duty_shadow == tgt_q) state_d = DONE;
          else                               state_d = STEP;
        end
      end
      DONE: begin
        drop_d = any_man;
        if (bus.ena) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shadow and all registered outputs; a STEP always finishes its pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      tgt_q           <= INIT_V;
      man_q           <= 1'b0;
      ready_q         <= 1'b0;
      bus.duty_shadow <= INIT_V;
      bus.inc_pulse   <= 1'b0;
      bus.dec_pulse   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err_range   <= 1'b0;
      bus.man_drop    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      man_q         <= man_d;
      ready_q       <= (state_d == IDLE);
      bus.inc_pulse <= (state_q == STEP) && (dir == UP);
      bus.dec_pulse <= (state_q == STEP) && (dir == DOWN);
      if (state_q == STEP)
        bus.duty_shadow <= (dir == UP) ? bus.duty_shadow + 1'b1 : bus.duty_shadow - 1'b1;
      bus.busy      <= (state_d != IDLE);
      bus.done      <= (state_q == DONE) && bus.ena;
      bus.err_range <= err_d;
      bus.man_drop  <= drop_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: ramps, clamping, manual steps, freeze, reset.
module tb_pwm_duty_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   acc;
  int   inc_q[$], dec_q[$], done_q[$], err_q[$], drop_q[$];

  pwm_duty_sequencer_if #(.DUTY_W(4)) bus ();

  pwm_duty_sequencer #(
    .DUTY_W(4), .DUTY_MAX(10), .DUTY_INIT(5), .GAP_W(8), .STEP_GAP(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: edge index of every pulse output, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.inc_pulse) inc_q.push_back(cyc);
    if (bus.dec_pulse) dec_q.push_back(cyc);
    if (bus.done)      done_q.push_back(cyc);
    if (bus.err_range) err_q.push_back(cyc);
    if (bus.man_drop)  drop_q.push_back(cyc);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    inc_q.delete(); dec_q.delete(); done_q.delete(); err_q.delete(); drop_q.delete();
  endtask

  task automatic send_tgt(input int d);
    clr();
    bus.tgt_valid = 1'b1;
    bus.tgt_duty  = 4'(d);
    tick();
    bus.tgt_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic man(input logic i, input logic d);
    bus.man_inc = i;
    bus.man_dec = d;
    tick();
    bus.man_inc = 1'b0;
    bus.man_dec = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, int'(n < 200), 1);
    tick();
    tick();
  endtask

  initial begin
    bus.ena = 1'b1; bus.tgt_valid = 1'b0; bus.tgt_duty = '0;
    bus.man_inc = 1'b0; bus.man_dec = 1'b0;
    tick(); tick();
    chk("rst_shadow", bus.duty_shadow, 5);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_ready",  bus.tgt_ready, 0);
    chk("rst_pulses", bus.inc_pulse | bus.dec_pulse | bus.done, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", bus.tgt_ready, 1);

    // 5 -> 8: three up-steps four cycles apart, done after the last gap
    send_tgt(8);
    chk("t8_ready_low", bus.tgt_ready, 0);
    wait_idle("t8");
    chk("t8_n_inc", inc_q.size(), 3);
    for (int i = 0; i < inc_q.size(); i++) chk($sformatf("t8_inc%0d", i), inc_q[i], acc + 1 + 4*i);
    chk("t8_shadow", bus.duty_shadow, 8);
    chk("t8_n_done", done_q.size(), 1);
    if (done_q.size() > 0) chk("t8_done_cyc", done_q[0], acc + 13);
    chk("t8_ready", bus.tgt_ready, 1);

    // 8 -> 2: six down-steps, no range error
    send_tgt(2);
    wait_idle("t2");
    chk("t2_n_dec", dec_q.size(), 6);
    for (int i = 0; i < dec_q.size(); i++) chk($sformatf("t2_dec%0d", i), dec_q[i], acc + 1 + 4*i);
    chk("t2_n_inc", inc_q.size(), 0);
    chk("t2_shadow", bus.duty_shadow, 2);
    chk("t2_n_err", err_q.size(), 0);

    // 13 is clamped to 10 and flagged the cycle after acceptance
    send_tgt(13);
    wait_idle("t13");
    chk("t13_n_err", err_q.size(), 1);
    if (err_q.size() > 0) chk("t13_err_cyc", err_q[0], acc);
    chk("t13_n_inc", inc_q.size(), 8);
    chk("t13_shadow", bus.duty_shadow, 10);

    // man_inc at the top limit: ignored, not dropped
    clr();
    man(1'b1, 1'b0);
    tick(); tick(); tick();
    chk("lim_n_inc", inc_q.size(), 0);
    chk("lim_n_drop", drop_q.size(), 0);
    chk("lim_shadow", bus.duty_shadow, 10);
    chk("lim_busy", bus.busy, 0);

    // target equal to shadow: no steps, done only
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send_tgt(5);
    wait_idle("teq");
    chk("teq_n_pulse", inc_q.size() + dec_q.size(), 0);
    chk("teq_n_done", done_q.size(), 1);
    if (done_q.size() > 0) chk("teq_done_cyc", done_q[0], acc + 1);
    chk("teq_shadow", bus.duty_shadow, 5);

    // man_inc during a ramp is dropped
    send_tgt(7);
    tick(); tick();
    bus.man_inc = 1'b1;
    tick();
    bus.man_inc = 1'b0;
    wait_idle("t7");
    chk("busy_drop_n", drop_q.size(), 1);
    chk("busy_drop_n_inc", inc_q.size(), 2);
    chk("busy_drop_shadow", bus.duty_shadow, 7);

    // man_inc + man_dec together in IDLE: both dropped
    clr();
    man(1'b1, 1'b1);
    tick(); tick();
    chk("both_drop_n", drop_q.size(), 1);
    chk("both_n_pulse", inc_q.size() + dec_q.size(), 0);
    chk("both_shadow", bus.duty_shadow, 7);

    // single manual decrement: one pulse, no done
    clr();
    man(1'b0, 1'b1);
    wait_idle("mdec");
    chk("mdec_n_dec", dec_q.size(), 1);
    if (dec_q.size() > 0) chk("mdec_cyc", dec_q[0], acc + 1);
    chk("mdec_n_done", done_q.size(), 0);
    chk("mdec_shadow", bus.duty_shadow, 6);

    // 6 -> 10 with ena low for 10 cycles in the first gap, then reset mid-ramp
    send_tgt(10);
    tick(); tick();
    bus.ena = 1'b0;
    repeat (10) tick();
    chk("frz_n_inc", inc_q.size(), 1);
    chk("frz_shadow", bus.duty_shadow, 7);
    bus.ena = 1'b1;
    repeat (4) tick();
    chk("frz_resume_n", inc_q.size(), 2);
    if (inc_q.size() > 1) chk("frz_resume_cyc", inc_q[1], acc + 15);
    chk("frz_shadow2", bus.duty_shadow, 8);
    #2 rst = 1'b1;
    #1;
    chk("arst_shadow", bus.duty_shadow, 5);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.tgt_ready, 0);
    repeat (4) tick();
    chk("arst_no_pulse", inc_q.size(), 2);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", bus.tgt_ready, 1);
    chk("post_rst_shadow", bus.duty_shadow, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
